// File: rtl/loader_pkg.sv
// Shared definitions for the Sobel loader blocks: sequencer state encoding and
// default counter/address widths.
package loader_pkg;

  localparam int unsigned DEF_COL_BITS  = 10;
  localparam int unsigned DEF_ROW_BITS  = 10;
  localparam int unsigned DEF_ADDR_BITS = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/raster_addr_gen_tc_counter.sv
// Up-counter with sync clear, load-to-zero and enable, plus a terminal-count
// flag that compares the current count against a runtime limit.
module tc_counter #(
  parameter int NumOfBit = 10
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                en,
  input  logic                load_zero,
  input  logic [NumOfBit-1:0] limit,
  output logic [NumOfBit-1:0] count,
  output logic                tc
);

  always_ff @(posedge clk) begin
    if (clear || load_zero) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/raster_addr_gen.sv
// 2-D raster walker: steps (Col,Row) over a WxH frame and issues one linear
// address per Valid/Ready beat, with line/frame markers and a Done pulse.
//
//   state   | meaning
//   IDLE    | waiting for Start; frame geometry latched on acceptance
//   RUN     | Valid high, one beat retired per Valid&&Ready
//   DONE    | one-cycle Done pulse, then back to IDLE
module raster_addr_gen
  import loader_pkg::*;
#(
  parameter int ColBits  = DEF_COL_BITS,
  parameter int RowBits  = DEF_ROW_BITS,
  parameter int AddrBits = DEF_ADDR_BITS
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic [ColBits-1:0]  Width,
  input  logic [RowBits-1:0]  Height,
  input  logic [AddrBits-1:0] Base,
  input  logic                Ready,
  output logic                Valid,
  output logic [ColBits-1:0]  Col,
  output logic [RowBits-1:0]  Row,
  output logic [AddrBits-1:0] Addr,
  output logic                EndOfLine,
  output logic                EndOfFrame,
  output logic                Busy,
  output logic                Done
);

  state_t             state;
  logic [ColBits-1:0] col_last;
  logic [RowBits-1:0] row_last;
  logic               col_tc;
  logic               row_tc;
  logic               accept;
  logic               empty;
  logic               beat;
  logic               line_wrap;

  assign accept    = (state == ST_IDLE) && Start;
  assign empty     = (Width == '0) || (Height == '0);
  assign beat      = Valid && Ready;
  // On the final beat both counters must hold, so wrap only below the last row.
  assign line_wrap = beat && col_tc && !row_tc;

  tc_counter #(.NumOfBit(ColBits)) u_col_cnt (
    .clk       (CLK),
    .clear     (Reset),
    .en        (beat && !col_tc),
    .load_zero (accept || line_wrap),
    .limit     (col_last),
    .count     (Col),
    .tc        (col_tc)
  );

  tc_counter #(.NumOfBit(RowBits)) u_row_cnt (
    .clk       (CLK),
    .clear     (Reset),
    .en        (line_wrap),
    .load_zero (accept),
    .limit     (row_last),
    .count     (Row),
    .tc        (row_tc)
  );

  assign EndOfLine  = Valid && col_tc;
  assign EndOfFrame = EndOfLine && row_tc;
  assign Busy       = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      Valid    <= 1'b0;
      Done     <= 1'b0;
      Addr     <= '0;
      col_last <= '0;
      row_last <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            col_last <= Width - 1'b1;
            row_last <= Height - 1'b1;
            Addr     <= Base;
            if (empty) begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              Valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (beat) begin
            if (EndOfFrame) begin
              Valid <= 1'b0;
              Done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              Addr <= Addr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
